// File: rtl/msg_build_arbiter.sv
// Round-robin arbiter sharing one message_build padding engine between NUM_CH hash job sources.
// Forwards the granted channel's config and data, tags engine output with its ID, and checks beat counts.
module msg_build_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  en,
  input  logic [NUM_CH*64-1:0]  ch_cfg_size,
  input  logic [NUM_CH*2-1:0]   ch_cfg_scheme,
  input  logic [NUM_CH-1:0]     ch_cfg_valid,
  output logic [NUM_CH-1:0]     ch_cfg_ready,
  input  logic [NUM_CH*512-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]     ch_data_in_last,
  input  logic [NUM_CH-1:0]     ch_data_in_valid,
  output logic [NUM_CH-1:0]     ch_data_in_ready,
  output logic [63:0]           mb_cfg_size,
  output logic [1:0]            mb_cfg_scheme,
  output logic                  mb_cfg_valid,
  input  logic                  mb_cfg_ready,
  output logic [511:0]          mb_data_in,
  output logic                  mb_data_in_last,
  output logic                  mb_data_in_valid,
  input  logic                  mb_data_in_ready,
  input  logic                  mb_data_out_last,
  input  logic                  mb_data_out_valid,
  input  logic                  mb_data_out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy,
  output logic                  len_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG,
    S_DATA,
    S_DRAIN
  } state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] grant, last_grant;
  logic [ID_W-1:0] pick;
  logic            pick_ok;
  logic [54:0]     beat_cnt, exp_beats;
  logic [54:0]     beat_inc, size_raw, size_beats;

  logic [63:0]     sel_size;
  logic [1:0]      sel_scheme;
  logic            sel_cfg_valid;
  logic [511:0]    sel_data;
  logic            sel_last;
  logic            sel_data_valid;

  logic            cfg_hs, data_hs, out_done;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = ID_W'((32'(last_grant) + i) % NUM_CH);
      if (!pick_ok && ch_cfg_valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    sel_size       = '0;
    sel_scheme     = '0;
    sel_cfg_valid  = 1'b0;
    sel_data       = '0;
    sel_last       = 1'b0;
    sel_data_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant == ID_W'(i)) begin
        sel_size       = ch_cfg_size[64*i +: 64];
        sel_scheme     = ch_cfg_scheme[2*i +: 2];
        sel_cfg_valid  = ch_cfg_valid[i];
        sel_data       = ch_data_in[512*i +: 512];
        sel_last       = ch_data_in_last[i];
        sel_data_valid = ch_data_in_valid[i];
      end
    end
  end

  always_comb begin
    mb_cfg_size      = sel_size;
    mb_cfg_scheme    = sel_scheme;
    mb_cfg_valid     = 1'b0;
    mb_data_in       = sel_data;
    mb_data_in_last  = sel_last;
    mb_data_in_valid = 1'b0;
    ch_cfg_ready     = '0;
    ch_data_in_ready = '0;
    case (state)
      S_CFG: begin
        mb_cfg_valid        = sel_cfg_valid;
        ch_cfg_ready[grant] = mb_cfg_ready;
      end
      S_DATA: begin
        mb_data_in_valid        = sel_data_valid;
        ch_data_in_ready[grant] = mb_data_in_ready;
      end
      default: ;
    endcase
  end

  assign cfg_hs   = (state == S_CFG) && sel_cfg_valid && mb_cfg_ready;
  assign data_hs  = (state == S_DATA) && sel_data_valid && mb_data_in_ready;
  assign out_done = mb_data_out_valid && mb_data_out_ready && mb_data_out_last;

  assign size_raw   = sel_size[63:9] + 55'(|sel_size[8:0]);
  assign size_beats = (size_raw == '0) ? 55'd1 : size_raw;
  assign beat_inc   = (&beat_cnt) ? beat_cnt : beat_cnt + 55'd1;

  assign out_id = grant;
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (en && pick_ok) state_nx = S_CFG;
      S_CFG:   if (cfg_hs) state_nx = S_DATA;
      S_DATA:  if (data_hs && sel_last) state_nx = S_DRAIN;
      S_DRAIN: if (out_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
      beat_cnt   <= '0;
      exp_beats  <= '0;
      len_err    <= 1'b0;
    end else begin
      state   <= state_nx;
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && pick_ok) grant <= pick;
        end
        S_CFG: begin
          if (cfg_hs) begin
            exp_beats <= size_beats;
            beat_cnt  <= '0;
          end
        end
        S_DATA: begin
          if (data_hs) begin
            beat_cnt <= beat_inc;
            if (sel_last) len_err <= (beat_inc != exp_beats);
          end
        end
        S_DRAIN: begin
          if (out_done) last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/msg_build_arbiter.md
Name: msg_build_arbiter

Overview:
- Shares one message_build padding engine between NUM_CH independent requesters (hash job sources).
- Picks a requester round-robin, forwards its config, then steers its data words into the engine until the message completes.
- Tags the engine output with the owning channel ID for the downstream hash core.
- Checks each requester's beat count against its declared size.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
ID_W, 2, width of channel ID = clog2(NUM_CH)

Ports:
clk  input  1  clock
sync_rst  input  1  synchronous active-high reset
en  input  1  high = new grants permitted; low only blocks new grants (in-flight message completes)
ch_cfg_size  input  NUM_CH*64  per-channel message size in bits, channel i at [64*i+:64]
ch_cfg_scheme  input  NUM_CH*2  per-channel scheme
ch_cfg_valid  input  NUM_CH  per-channel config valid
ch_cfg_ready  output  NUM_CH  per-channel config ready
ch_data_in  input  NUM_CH*512  per-channel data word
ch_data_in_last  input  NUM_CH  per-channel last word
ch_data_in_valid  input  NUM_CH  per-channel data valid
ch_data_in_ready  output  NUM_CH  per-channel data ready
mb_cfg_size  output  64  to engine cfg_size
mb_cfg_scheme  output  2  to engine cfg_scheme
mb_cfg_valid  output  1  to engine cfg_valid
mb_cfg_ready  input  1  from engine cfg_ready
mb_data_in  output  512  to engine data_in
mb_data_in_last  output  1  to engine data_in_last
mb_data_in_valid  output  1  to engine data_in_valid
mb_data_in_ready  input  1  from engine data_in_ready
mb_data_out_last  input  1  engine data_out_last (observed only)
mb_data_out_valid  input  1  engine data_out_valid (observed only)
mb_data_out_ready  input  1  downstream ready on engine output (observed only)
out_id  output  ID_W  owner channel of current engine output
busy  output  1  a message is in flight
len_err  output  1  one-cycle pulse: beat count differs from expected

Behaviour:
- Reset (sync_rst high at a clk edge): state=IDLE; grant=0; last_grant=NUM_CH-1; beat_cnt=0; exp_beats=0; len_err=0; busy=0; out_id=0.
  - Reset has priority over everything and aborts any in-flight message; the engine is reset alongside by the top level.
- Combinational outputs are driven only from grant and state.
  - All ch_*_ready not owned by grant are 0.
  - mb_*_valid are 0 outside their state.
  - Requesters hold cfg and data stable while valid.
- IDLE: if en and |ch_cfg_valid, grant = first valid channel searching last_grant+1, +2, ... (modulo NUM_CH); go to CFG next cycle. busy=1 from CFG onward.
- CFG:
  - mb_cfg_* = channel grant's config; mb_cfg_valid = ch_cfg_valid[grant]; ch_cfg_ready[grant] = mb_cfg_ready.
  - On handshake: latch exp_beats = max(1, size[63:9] + |size[8:0]) (55-bit); beat_cnt=0; go to DATA.
- DATA:
  - mb_data_in* = channel grant's data; ch_data_in_ready[grant] = mb_data_in_ready.
  - Each handshake increments beat_cnt (saturating at all-ones).
  - On handshake with last=1: final = beat_cnt+1; len_err pulses next cycle if final != exp_beats; go to DRAIN.
  - Non-last beat making beat_cnt+1 == exp_beats: no error yet, wait for last.
- DRAIN: wait for mb_data_out_valid & mb_data_out_ready & mb_data_out_last; then last_grant=grant, busy=0, go to IDLE.
  - Earliest next grant is the cycle after IDLE is entered; no new cfg is forwarded while the engine still holds output.
- out_id = grant in all states and is stable from CFG until the DRAIN exit.
- en dropping mid-message has no effect until IDLE.
- Single requester repeatedly valid: granted back-to-back, with one IDLE cycle between messages.
- Size 0: exp_beats=1.

Test Plan:
- Ch1 only, size=24, one beat with last -> grant=1, one mb_cfg handshake, one data beat forwarded, DRAIN exits on engine last, len_err=0, busy back to 0.
- Ch0..3 all valid at reset release, size=512 each -> grants in order 0,1,2,3; out_id matches per message; no channel's ready asserted out of turn.
- Ch2 size=1025, sends 3 beats with last on third -> exp_beats=3, len_err=0; repeat with last on beat 2 -> len_err pulses once.
- Ch0 in DATA while downstream ready held low 20 cycles -> arbiter stays in DRAIN, ch3 cfg_valid high gets no cfg_ready until engine last handshake.
- en=0 with ch1 valid -> no grant; en=1 -> grant next cycle; en=0 mid-DATA -> message completes normally.
- sync_rst asserted mid-DATA -> next cycle state IDLE, all ready/valid outputs 0, busy=0, last_grant=NUM_CH-1 (next grant to ch0 if valid).
